// File: rtl/fell_mon_pkg.sv
// Shared definitions for the falling-edge response monitor.
//   WINDOW_DEF / CNT_W_DEF : default response window and counter width
//   sat_add                : add with clamp to the all-ones value of a w-bit counter
//   popcnt                 : number of set bits in a vector (up to 32 bits)
package fell_mon_pkg;

  localparam int WINDOW_DEF = 1;
  localparam int CNT_W_DEF  = 16;

  // The sum is formed one bit wider than the counter so the carry out is
  // visible, then clamped to 2^w-1. Valid for w in 1..32.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, cnt} + {1'b0, inc};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic [31:0] popcnt(input logic [31:0] vec);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {31'b0, vec[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/fell_resp_monitor_fall_detect.sv
// Falling-edge detector for the antecedent signal.
//   clk, rst : clock and synchronous active-high reset
//   en       : qualifies the detected fall (history flop tracks d regardless)
//   d        : signal being watched
//   fell     : high in the cycle d is sampled low after having been sampled high
module fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic fell
);

  logic a_q;

  // Clearing the history to 0 means a signal that is already low when reset
  // is released never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= 1'b0;
    end else begin
      a_q <= d;
    end
  end

  assign fell = a_q & ~d & en;

endmodule

// File: rtl/fell_resp_monitor.sv
// In-design checker for "every fall of sig_a is followed by sig_b high within
// WINDOW cycles (the fall cycle itself counts as cycle 0)". Each fall opens an
// independent attempt, so overlapping attempts are tracked individually.
//   clk, rst   : clock, synchronous active-high reset
//   en         : allows new attempts to open; open attempts always resolve
//   clr        : clears counters and err_sticky
//   sig_a      : antecedent (its falling edge opens an attempt)
//   sig_b      : consequent (closes every open attempt as passed)
//   pass_pulse : one-cycle pulse, at least one attempt passed last cycle
//   fail_pulse : one-cycle pulse, an attempt expired last cycle
//   pass_cnt   : saturating count of passed attempts
//   fail_cnt   : saturating count of failed attempts
//   pending    : at least one attempt still open
//   err_sticky : set by any failure, cleared by clr or rst
module fell_resp_monitor
  import fell_mon_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             sig_a,
  input  logic             sig_b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             pending,
  output logic             err_sticky
);

  // With WINDOW=0 no attempt survives its first cycle; a 1-bit vector that
  // never loads anything is kept so the datapath needs no special casing.
  localparam int PW = (WINDOW > 0) ? WINDOW : 1;

  logic             fell;
  logic [PW-1:0]    p_q, p_d;
  logic [31:0]      npass;
  logic             nfail;

  logic             pass_pulse_q, pass_pulse_d;
  logic             fail_pulse_q, fail_pulse_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;

  fall_detect u_fall_detect (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .d    (sig_a),
    .fell (fell)
  );

  // p_q[i] is an attempt opened i+1 cycles ago. sig_b closes all of them at
  // once; otherwise they age by one and the oldest one expires.
  always_comb begin
    npass = '0;
    nfail = 1'b0;
    p_d   = p_q;
    if (sig_b) begin
      npass = popcnt(32'(p_q)) + 32'(fell);
      p_d   = '0;
    end else if (WINDOW == 0) begin
      nfail = fell;
      p_d   = '0;
    end else begin
      nfail = p_q[PW-1];
      p_d   = (p_q << 1) | PW'(fell);
    end
  end

  // A clear coincident with a result keeps that result's contribution.
  always_comb begin
    pass_pulse_d = (npass != 32'd0);
    fail_pulse_d = nfail;
    pass_cnt_d   = CNT_W'(sat_add(clr ? 32'd0 : 32'(pass_cnt_q), npass, CNT_W));
    fail_cnt_d   = CNT_W'(sat_add(clr ? 32'd0 : 32'(fail_cnt_q), 32'(nfail), CNT_W));
    err_d        = (err_q & ~clr) | nfail;
    pending_d    = (|p_d) | (fell & ~sig_b & (WINDOW > 0));
  end

  // Reset drops open attempts without reporting them.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q          <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      pending_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      p_q          <= p_d;
      pass_pulse_q <= pass_pulse_d;
      fail_pulse_q <= fail_pulse_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
    end
  end

  assign pass_pulse = pass_pulse_q;
  assign fail_pulse = fail_pulse_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign pending    = pending_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_fell_resp_monitor.sv
// Four monitors with different WINDOW / CNT_W share one directed stimulus.
// An attempt-age model predicts every output each cycle; literal checks at
// chosen points pin down the expected behaviour directly.
module tb_fell_resp_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic sig_a = 1'b0;
  logic sig_b = 1'b0;

  always #2 clk = ~clk;

  logic [3:0]  pp, fp, pend, er;
  logic [15:0] pc0, fc0, pc1, fc1, pc3, fc3;
  logic [1:0]  pc2, fc2;

  fell_resp_monitor #(.WINDOW(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_a(sig_a), .sig_b(sig_b),
    .pass_pulse(pp[0]), .fail_pulse(fp[0]), .pass_cnt(pc0), .fail_cnt(fc0),
    .pending(pend[0]), .err_sticky(er[0]));
  fell_resp_monitor #(.WINDOW(3), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_a(sig_a), .sig_b(sig_b),
    .pass_pulse(pp[1]), .fail_pulse(fp[1]), .pass_cnt(pc1), .fail_cnt(fc1),
    .pending(pend[1]), .err_sticky(er[1]));
  fell_resp_monitor #(.WINDOW(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_a(sig_a), .sig_b(sig_b),
    .pass_pulse(pp[2]), .fail_pulse(fp[2]), .pass_cnt(pc2), .fail_cnt(fc2),
    .pending(pend[2]), .err_sticky(er[2]));
  fell_resp_monitor #(.WINDOW(0), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_a(sig_a), .sig_b(sig_b),
    .pass_pulse(pp[3]), .fail_pulse(fp[3]), .pass_cnt(pc3), .fail_cnt(fc3),
    .pending(pend[3]), .err_sticky(er[3]));

  function automatic int pcnt(input int i);
    case (i)
      0: return int'(pc0);
      1: return int'(pc1);
      2: return int'(pc2);
      default: return int'(pc3);
    endcase
  endfunction

  function automatic int fcnt(input int i);
    case (i)
      0: return int'(fc0);
      1: return int'(fc1);
      2: return int'(fc2);
      default: return int'(fc3);
    endcase
  endfunction

  int cmp_n = 0;
  int fail_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    cmp_n++;
    if (act != exp) begin
      fail_n++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: count open attempts by age (0 = opened this cycle).
  int WIN[4]  = '{1, 3, 1, 0};
  int MAXC[4] = '{65535, 65535, 3, 65535};
  int age_cnt[4][8];
  int m_pc[4], m_fc[4], m_pp[4], m_fp[4], m_pend[4], m_err[4];
  bit m_prev_a;
  bit m_fell;
  int np, nf, rem;

  always @(posedge clk) begin
    if (rst) begin
      m_prev_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int a = 0; a < 8; a++) age_cnt[i][a] = 0;
        m_pc[i] = 0; m_fc[i] = 0; m_pp[i] = 0; m_fp[i] = 0;
        m_pend[i] = 0; m_err[i] = 0;
      end
    end else begin
      m_fell = m_prev_a & ~sig_a & en;
      m_prev_a = sig_a;
      for (int i = 0; i < 4; i++) begin
        np = 0; nf = 0; rem = 0;
        if (m_fell) age_cnt[i][0]++;
        if (sig_b) begin
          for (int a = 0; a <= WIN[i]; a++) begin
            np += age_cnt[i][a];
            age_cnt[i][a] = 0;
          end
        end else begin
          nf = age_cnt[i][WIN[i]];
          for (int a = WIN[i]; a >= 1; a--) age_cnt[i][a] = age_cnt[i][a-1];
          age_cnt[i][0] = 0;
          for (int a = 0; a <= WIN[i]; a++) rem += age_cnt[i][a];
        end
        m_pp[i]   = (np != 0) ? 1 : 0;
        m_fp[i]   = (nf != 0) ? 1 : 0;
        m_pc[i]   = (clr ? 0 : m_pc[i]) + np;
        if (m_pc[i] > MAXC[i]) m_pc[i] = MAXC[i];
        m_fc[i]   = (clr ? 0 : m_fc[i]) + nf;
        if (m_fc[i] > MAXC[i]) m_fc[i] = MAXC[i];
        m_err[i]  = ((clr ? 0 : m_err[i]) != 0 || nf != 0) ? 1 : 0;
        m_pend[i] = (rem != 0) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("i%0d pass_pulse", i), int'(pp[i]), m_pp[i]);
      chk($sformatf("i%0d fail_pulse", i), int'(fp[i]), m_fp[i]);
      chk($sformatf("i%0d pass_cnt", i), pcnt(i), m_pc[i]);
      chk($sformatf("i%0d fail_cnt", i), fcnt(i), m_fc[i]);
      chk($sformatf("i%0d pending", i), int'(pend[i]), m_pend[i]);
      chk($sformatf("i%0d err_sticky", i), int'(er[i]), m_err[i]);
    end
  end

  // Drive at a falling edge; return at the next falling edge, after the
  // intervening rising edge has evaluated and registered the results.
  task automatic drive(input bit a, input bit b, input bit e, input bit c);
    sig_a = a; sig_b = b; en = e; clr = c;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("reset pass_cnt", pcnt(0), 0);
    chk("reset pending", int'(pend[0]), 0);
    rst = 1'b0;

    // sig_a low through reset release: no attempt.
    drive(0, 0, 1, 0);
    chk("low-at-release pending", int'(pend[0]), 0);
    chk("low-at-release fail_pulse w0", int'(fp[3]), 0);
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 0);

    // Fall with sig_b high in the same cycle.
    drive(0, 1, 1, 0);
    chk("t1 pass_pulse", int'(pp[0]), 1);
    chk("t1 pass_cnt", pcnt(0), 1);
    chk("t1 fail_cnt", fcnt(0), 0);
    chk("t1 w0 pass_pulse", int'(pp[3]), 1);
    drive(0, 0, 1, 0);
    chk("t1 pulse width", int'(pp[0]), 0);

    // Fall with no response.
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("t2 pending", int'(pend[0]), 1);
    chk("t6 w0 fail_pulse", int'(fp[3]), 1);
    chk("t6 w0 pending", int'(pend[3]), 0);
    chk("t6 w0 fail_cnt", fcnt(3), 1);
    drive(0, 0, 1, 0);
    chk("t2 fail_pulse", int'(fp[0]), 1);
    chk("t2 fail_cnt", fcnt(0), 1);
    chk("t2 err_sticky", int'(er[0]), 1);
    chk("t2 pending after fail", int'(pend[0]), 0);
    drive(0, 0, 1, 0);
    chk("t2 fail pulse width", int'(fp[0]), 0);
    chk("t2 w3 still pending", int'(pend[1]), 1);
    drive(0, 0, 1, 0);
    chk("t2 w3 fail_pulse", int'(fp[1]), 1);
    drive(0, 0, 1, 1);
    chk("clr fail_cnt", fcnt(0), 0);
    chk("clr err_sticky", int'(er[0]), 0);
    chk("clr pass_cnt", pcnt(0), 0);

    // WINDOW=3: falls two cycles apart, both closed by one sig_b.
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);
    chk("t3 w3 pass_pulse", int'(pp[1]), 1);
    chk("t3 w3 pass_cnt", pcnt(1), 2);
    chk("t3 w3 pending", int'(pend[1]), 0);

    // clr coinciding with a pass keeps that pass.
    drive(1, 0, 1, 0);
    drive(0, 1, 1, 1);
    chk("clr+pass pass_cnt", pcnt(0), 1);
    chk("clr+pass err_sticky", int'(er[0]), 0);
    chk("clr+pass w3 pass_cnt", pcnt(1), 1);

    // Fall while disabled: no attempt.
    drive(1, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("en=0 pending", int'(pend[0]), 0);
    chk("en=0 w0 fail_pulse", int'(fp[3]), 0);
    drive(0, 0, 0, 0);
    chk("en=0 fail_pulse", int'(fp[0]), 0);

    // Five passes into a 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 1, 0);
      drive(0, 1, 1, 0);
    end
    chk("t5 cnt_w2 saturates", pcnt(2), 3);
    chk("t5 cnt_w16 count", pcnt(0), 6);

    // Reset with attempts open: they vanish without a failure.
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("t5 w3 pending before rst", int'(pend[1]), 1);
    rst = 1'b1;
    drive(0, 0, 1, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 0);
    chk("rst w3 fail_cnt", fcnt(1), 0);
    chk("rst w3 err_sticky", int'(er[1]), 0);
    chk("rst w3 pending", int'(pend[1]), 0);
    chk("rst pass_cnt", pcnt(0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
